regfile_wb_arbiter: RTL and testbench

//   Shares the single register-file write port (regWrite/destReg/writeData) between NREQ writeback

---
 rtl/regfile_wb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin arbiter that shares the single register-file write
//            port among NREQ writeback requesters, together with a 32-entry
//            pending-write scoreboard that gives read-after-write hazard
//            flags to the decode stage.
// Ports    : clk, reset (sync, active-low)
//            req_valid/req_dest/req_data -> req_ready (one-hot grant)
//            issue_valid/issue_dest      -> issue_ready
//            srcRegA/srcRegB             -> hazardA/hazardB
//            regWrite/destReg/writeData  registered register-file write port
//            busy_vec                    scoreboard contents
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_dest,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_dest,
    output logic                     issue_ready,
    input  logic [ADDR_W-1:0]        srcRegA,
    input  logic [ADDR_W-1:0]        srcRegB,
    output logic                     hazardA,
    output logic                     hazardB,
    output logic                     regWrite,
    output logic [ADDR_W-1:0]        destReg,
    output logic [DATA_W-1:0]        writeData,
    output logic [31:0]              busy_vec
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  rr_ptr_q,     rr_ptr_d;
    logic [31:0]       busy_q,       busy_d;
    logic              reg_write_q,  reg_write_d;
    logic [ADDR_W-1:0] dest_reg_q,   dest_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NREQ-1:0]   upper_mask;
    logic [NREQ-1:0]   masked_valid;
    logic [NREQ-1:0]   pick_vec;
    logic              grant_valid;
    logic [PTR_W-1:0]  grant_idx;
    logic [ADDR_W-1:0] grant_dest;
    logic [DATA_W-1:0] grant_data;

    // Round-robin done as two fixed-priority passes: first among indices at
    // or above the pointer, and if none of those is valid, among all of
    // them (which is the wrap-around part of the search).
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            upper_mask[i] = (PTR_W'(i) >= rr_ptr_q);
        end
        masked_valid = req_valid & upper_mask;
        pick_vec     = (|masked_valid) ? masked_valid : req_valid;

        // No grant while reset is asserted, so nothing is consumed.
        grant_valid  = reset & (|pick_vec);

        grant_idx  = '0;
        grant_dest = '0;
        grant_data = '0;
        // Descending scan: the lowest set bit is the last one assigned.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick_vec[i]) begin
                grant_idx  = PTR_W'(i);
                grant_dest = req_dest[i*ADDR_W +: ADDR_W];
                grant_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = grant_valid ? (NREQ'(1) << grant_idx) : '0;

    // ------------------------------------------------------------------
    // Scoreboard and issue handshake
    // ------------------------------------------------------------------
    logic grant_clears;
    logic clr_hit;
    logic issue_fire;

    assign grant_clears = grant_valid && (grant_dest != '0);

    // A writeback landing on the issued destination this cycle frees it,
    // so the new producer may issue immediately.
    assign clr_hit     = grant_clears && (grant_dest == issue_dest);
    assign issue_ready = (issue_dest == '0) | ~busy_q[issue_dest] | clr_hit;
    assign issue_fire  = issue_valid && issue_ready && (issue_dest != '0);

    always_comb begin
        busy_d = busy_q;
        if (grant_clears) begin
            busy_d[grant_dest] = 1'b0;
        end
        // Applied after the clear so a same-cycle set wins.
        if (issue_fire) begin
            busy_d[issue_dest] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Hazards reflect the registered scoreboard only; a clear takes effect
    // the cycle the register file is actually written.
    assign hazardA  = busy_q[srcRegA];
    assign hazardB  = busy_q[srcRegB];
    assign busy_vec = busy_q;

    // ------------------------------------------------------------------
    // Pointer and write-port next state
    // ------------------------------------------------------------------
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        reg_write_d  = 1'b0;
        dest_reg_d   = dest_reg_q;
        write_data_d = write_data_q;

        if (grant_valid) begin
            rr_ptr_d = (grant_idx == PTR_W'(NREQ - 1)) ? '0
                                                       : grant_idx + PTR_W'(1);
        end
        // Writes to register 0 are consumed but never reach the file.
        if (grant_clears) begin
            reg_write_d  = 1'b1;
            dest_reg_d   = grant_dest;
            write_data_d = grant_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q     <= '0;
            busy_q       <= '0;
            reg_write_q  <= 1'b0;
            dest_reg_q   <= '0;
            write_data_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            busy_q       <= busy_d;
            reg_write_q  <= reg_write_d;
            dest_reg_q   <= dest_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign regWrite  = reg_write_q;
    assign destReg   = dest_reg_q;
    assign writeData = write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter. A behavioural model
//            (round-robin search, scoreboard bit array, one-cycle write
//            pipeline) predicts every output each cycle; directed sequences
//            are followed by randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int NREQ   = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_dest;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   issue_valid;
    logic [ADDR_W-1:0]      issue_dest;
    logic                   issue_ready;
    logic [ADDR_W-1:0]      srcRegA, srcRegB;
    logic                   hazardA, hazardB;
    logic                   regWrite;
    logic [ADDR_W-1:0]      destReg;
    logic [DATA_W-1:0]      writeData;
    logic [31:0]            busy_vec;

    regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_dest(req_dest), .req_data(req_data),
        .req_ready(req_ready),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
        .srcRegA(srcRegA), .srcRegB(srcRegB), .hazardA(hazardA), .hazardB(hazardB),
        .regWrite(regWrite), .destReg(destReg), .writeData(writeData),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    // Stimulus held per requester
    logic              rv   [NREQ];
    logic [ADDR_W-1:0] rdst [NREQ];
    logic [DATA_W-1:0] rdat [NREQ];

    // Reference model
    bit          m_init;
    int          m_ptr;
    bit          m_busy [32];
    bit          m_we;
    int          m_dest;
    logic [31:0] m_data;
    int          m_gidx;   // granted requester of the last step, -1 if none

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, predict, compare, clock, update the model.
    task automatic step();
        int          gi;
        logic [NREQ-1:0] exp_ready;
        bit          exp_iready;
        logic [31:0] exp_busy;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]                 = rv[i];
            req_dest[i*ADDR_W +: ADDR_W] = rdst[i];
            req_data[i*DATA_W +: DATA_W] = rdat[i];
        end
        #1;
        gi = -1;
        if (reset) begin
            for (int k = 0; k < NREQ; k++) begin
                if (gi < 0 && rv[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
            end
        end
        exp_ready = '0;
        if (gi >= 0) exp_ready[gi] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));

        if (m_init) begin
            exp_iready = (issue_dest == 0) || !m_busy[issue_dest] ||
                         (gi >= 0 && rdst[gi] != 0 && rdst[gi] == issue_dest);
            for (int r = 0; r < 32; r++) exp_busy[r] = m_busy[r];
            check("issue_ready", 64'(issue_ready), 64'(exp_iready));
            check("hazardA", 64'(hazardA), 64'(m_busy[srcRegA]));
            check("hazardB", 64'(hazardB), 64'(m_busy[srcRegB]));
            check("busy_vec", 64'(busy_vec), 64'(exp_busy));
            check("regWrite", 64'(regWrite), 64'(m_we));
            if (m_we) begin
                check("destReg", 64'(destReg), 64'(m_dest));
                check("writeData", 64'(writeData), 64'(m_data));
            end
        end

        @(posedge clk);
        if (!reset) begin
            m_init = 1;
            m_ptr  = 0;
            m_we   = 0;
            for (int r = 0; r < 32; r++) m_busy[r] = 0;
            exp_iready = 0;
        end else begin
            m_we = (gi >= 0) && (rdst[gi] != 0);
            if (m_we) begin
                m_dest = int'(rdst[gi]);
                m_data = rdat[gi];
            end
            if (gi >= 0) begin
                m_ptr = (gi + 1) % NREQ;
                if (rdst[gi] != 0) m_busy[rdst[gi]] = 0;
            end
            if (issue_valid && exp_iready && issue_dest != 0) m_busy[issue_dest] = 1;
        end
        m_gidx = gi;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 0; rdst[i] = '0; rdat[i] = '0;
        end
        issue_valid = 0; issue_dest = '0; srcRegA = '0; srcRegB = '0;
    endtask

    initial begin
        m_init = 0; m_ptr = 0; m_we = 0; m_dest = 0; m_data = '0; m_gidx = -1;
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);

        // Reset with all requesters valid, then round-robin with 5/6/7
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1; rdst[i] = ADDR_W'(5 + i); rdat[i] = 32'hA000_0000 + i;
        end
        step(); step();
        reset = 1'b1;
        for (int n = 0; n < 7; n++) step();
        idle_inputs();
        step();

        // Single requester 1: one-cycle write latency
        rv[1] = 1; rdst[1] = 5'd9; rdat[1] = 32'hDEADBEEF;
        step();
        rv[1] = 0;
        step(); step();

        // Write to register 0 consumes the grant, no register-file write
        rv[0] = 1; rdst[0] = 5'd0; rdat[0] = 32'h1234;
        step();
        rv[0] = 0;
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1; rdst[i] = ADDR_W'(20 + i); rdat[i] = 32'hB0 + i;
        end
        step();   // pointer is now 1: requester 1 wins
        idle_inputs();
        step();

        // Scoreboard: issue 12, re-issue blocked, writeback clears
        issue_valid = 1; issue_dest = 5'd12; srcRegA = 5'd12; srcRegB = 5'd3;
        step();
        step();                      // second issue to 12 is refused
        issue_valid = 0;
        rv[2] = 1; rdst[2] = 5'd12; rdat[2] = 32'hC0FFEE;
        step();
        rv[2] = 0;
        step();

        // Set/clear collision on register 12
        issue_valid = 1; issue_dest = 5'd12;
        step();
        rv[0] = 1; rdst[0] = 5'd12; rdat[0] = 32'h5555_AAAA;
        step();
        idle_inputs();
        srcRegA = 5'd12;
        step(); step();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 63) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!rv[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rv[i]   = 1;
                        rdst[i] = ADDR_W'($urandom_range(0, 15));
                        rdat[i] = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    rv[i] = 0;
                end
            end
            issue_valid = $urandom_range(0, 1) == 1;
            issue_dest  = ADDR_W'($urandom_range(0, 15));
            srcRegA     = ADDR_W'($urandom_range(0, 15));
            srcRegB     = ADDR_W'($urandom_range(0, 31));
            step();
            if (m_gidx >= 0) rv[m_gidx] = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
